dram_rr_scheduler: RTL and testbench

Two-requester DRAM access scheduler placed between the CPU ports (port 0: instruction fetch, read-only; port 1: data, read/write) and the DRAM controller. It arbitrates round-robin, issues exactly one single-cycle DRAM command per transaction, and waits for completion. It then returns data or a write acknowledge to the winning port. A watchdog aborts transactions the controller never completes.

---
 rtl/dram_rr_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dram_rr_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dram_rr_scheduler : two-port round-robin DRAM access scheduler with watchdog
// Revision: 1.0
// ============================================================================
module dram_rr_scheduler #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0: instruction fetch, read-only
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_req_read,
  output logic [DATA_W-1:0] p0_data_out,
  output logic              p0_done,
  output logic              p0_err,
  // port 1: data, read/write
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data_in,
  input  logic              p1_req_read,
  input  logic              p1_req_write,
  output logic [DATA_W-1:0] p1_data_out,
  output logic              p1_done,
  output logic              p1_err,
  // DRAM controller side
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              dram_req_read,
  output logic              dram_req_write,
  input  logic [DATA_W-1:0] dram_data_out,
  input  logic              dram_data_out_valid,
  input  logic              dram_write_complete,
  // status
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  // Last watchdog value at which a WAIT cycle without completion times out
  localparam logic [TO_W-1:0] c_wdog_last = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;
  logic              r_op_write;
  logic [TO_W-1:0]   r_wdog;

  logic              w_p0_pend;
  logic              w_p1_pend;
  logic              w_pick_p1;
  logic              w_start;
  logic              w_complete;
  logic              w_timeout;

  always_comb begin
    w_p0_pend    = p0_req_read;
    w_p1_pend    = p1_req_read | p1_req_write;
    // On a tie the port that did not win last time is served
    w_pick_p1    = w_p1_pend & (~w_p0_pend | ~r_last_grant);
    w_start      = (r_state == S_IDLE) & (w_p0_pend | w_p1_pend);
    w_complete   = (r_state == S_WAIT) &
                   (r_op_write ? dram_write_complete : dram_data_out_valid);
    w_timeout    = (r_state == S_WAIT) & ~w_complete & (r_wdog == c_wdog_last);
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_ISSUE;
      S_ISSUE:  w_state_next = S_WAIT;
      S_WAIT:   if (w_complete || w_timeout) w_state_next = S_RETIRE;
      S_RETIRE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant   <= 1'b1;
      r_op_write     <= 1'b0;
      r_wdog         <= '0;
      grant          <= 1'b0;
      dram_addr      <= '0;
      dram_data_in   <= '0;
      dram_req_read  <= 1'b0;
      dram_req_write <= 1'b0;
      p0_data_out    <= '0;
      p0_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_data_out    <= '0;
      p1_done        <= 1'b0;
      p1_err         <= 1'b0;
    end else begin
      dram_req_read  <= 1'b0;
      dram_req_write <= 1'b0;
      p0_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_done        <= 1'b0;
      p1_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            grant        <= w_pick_p1;
            r_last_grant <= w_pick_p1;
            if (w_pick_p1) begin
              // A simultaneous read and write from port 1 is served as a write
              dram_addr      <= p1_addr;
              dram_data_in   <= p1_data_in;
              r_op_write     <= p1_req_write;
              dram_req_write <= p1_req_write;
              dram_req_read  <= ~p1_req_write;
            end else begin
              dram_addr      <= p0_addr;
              dram_data_in   <= '0;
              r_op_write     <= 1'b0;
              dram_req_read  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_wdog <= '0;
        end
        S_WAIT: begin
          if (w_complete) begin
            if (grant) begin
              p1_done <= 1'b1;
              if (!r_op_write) p1_data_out <= dram_data_out;
            end else begin
              p0_done <= 1'b1;
              p0_data_out <= dram_data_out;
            end
          end else if (w_timeout) begin
            if (grant) begin
              p1_done <= 1'b1;
              p1_err  <= 1'b1;
            end else begin
              p0_done <= 1'b1;
              p0_err  <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dram_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dram_rr_scheduler : scoreboard bench for the round-robin DRAM scheduler
// Revision: 1.0
// ============================================================================
module tb_dram_rr_scheduler;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 10;
  localparam int TO_W    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0;
  logic              p0_req_read = 1'b0;
  logic [DATA_W-1:0] p0_data_out;
  logic              p0_done, p0_err;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_data_in = '0;
  logic              p1_req_read = 1'b0;
  logic              p1_req_write = 1'b0;
  logic [DATA_W-1:0] p1_data_out;
  logic              p1_done, p1_err;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_data_in;
  logic              dram_req_read, dram_req_write;
  logic [DATA_W-1:0] dram_data_out;
  logic              dram_data_out_valid, dram_write_complete;
  logic              busy, grant;

  // DRAM model drive plus bench-injected stray strobes
  logic              resp_en = 1'b1;
  int                resp_lat = 3;
  logic              resp_valid = 1'b0, resp_wc = 1'b0;
  logic [DATA_W-1:0] resp_data = '0;
  logic              spur_valid = 1'b0, spur_wc = 1'b0;
  logic [DATA_W-1:0] spur_data = '0;

  assign dram_data_out_valid = resp_valid | spur_valid;
  assign dram_write_complete = resp_wc | spur_wc;
  assign dram_data_out       = spur_valid ? spur_data : resp_data;

  dram_rr_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr), .p0_req_read(p0_req_read), .p0_data_out(p0_data_out),
    .p0_done(p0_done), .p0_err(p0_err),
    .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_req_read(p1_req_read),
    .p1_req_write(p1_req_write), .p1_data_out(p1_data_out),
    .p1_done(p1_done), .p1_err(p1_err),
    .dram_addr(dram_addr), .dram_data_in(dram_data_in),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
    .dram_write_complete(dram_write_complete),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct { logic write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } cmd_t;
  typedef struct { logic port; logic err; logic [DATA_W-1:0] data; } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  cmd_t mc;
  res_t mr;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_cmd_cyc = 0;
  int   last_done_cyc = 0;
  logic prev_cmd = 1'b0;
  logic [DATA_W-1:0] exp_p0 = '0;
  logic [DATA_W-1:0] exp_p1 = '0;

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    return (a == 24'h000100) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: command and completion checks against the scoreboard queues
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_cmd = 1'b0;
    end else begin
      if (dram_req_read || dram_req_write) begin
        chk("cmd_one_cycle", prev_cmd, 0);
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          mc = cmd_q.pop_front();
          chk("cmd_write", dram_req_write, mc.write);
          chk("cmd_read", dram_req_read, !mc.write);
          chk("cmd_addr", dram_addr, mc.addr);
          if (mc.write) chk("cmd_wdata", dram_data_in, mc.data);
        end
        last_cmd_cyc = cyc;
      end
      prev_cmd = dram_req_read || dram_req_write;
      if (p0_done || p1_done) begin
        chk("done_exclusive", p0_done && p1_done, 0);
        chk("done_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          mr = res_q.pop_front();
          chk("done_port", p1_done, mr.port);
          chk("done_err", mr.port ? p1_err : p0_err, mr.err);
          chk("done_data", mr.port ? p1_data_out : p0_data_out, mr.data);
          chk("done_grant", grant, mr.port);
        end
        last_done_cyc = cyc;
      end
    end
  end

  // DRAM responder: answers each command resp_lat cycles later when enabled
  initial begin : g_dram_model
    logic              rw;
    logic [ADDR_W-1:0] ra;
    forever begin
      @(negedge clk);
      if (rst_n && resp_en && (dram_req_read || dram_req_write)) begin
        rw = dram_req_write;
        ra = dram_addr;
        repeat (resp_lat) @(posedge clk);
        #1;
        if (rw) resp_wc = 1'b1;
        else begin
          resp_data  = rd_data(ra);
          resp_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        resp_wc    = 1'b0;
        resp_valid = 1'b0;
      end
    end
  end

  task automatic wait_done(input int maxc, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    @(posedge clk);
    #1;
    if (drop) begin
      p0_req_read  = 1'b0;
      p1_req_read  = 1'b0;
      p1_req_write = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, grant, dram_req_read, dram_req_write, p0_done, p1_done, p0_err, p1_err}, 0);
    chk("rst_dram", {dram_addr, dram_data_in}, 0);
    chk("rst_data", {p0_data_out, p1_data_out}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single p0 read
    p0_addr = 24'h000100; p0_req_read = 1'b1;
    exp_p0 = rd_data(24'h000100);
    cmd_q.push_back('{write: 1'b0, addr: 24'h000100, data: '0});
    res_q.push_back('{port: 1'b0, err: 1'b0, data: exp_p0});
    wait_done(40, 1);
    @(negedge clk);
    chk("busy_after_retire", busy, 0);

    // p1 write; a read-valid strobe during WAIT must be ignored
    @(posedge clk); #1;
    resp_lat = 4;
    p1_addr = 24'h0000A0; p1_data_in = 32'h12345678; p1_req_write = 1'b1;
    cmd_q.push_back('{write: 1'b1, addr: 24'h0000A0, data: 32'h12345678});
    res_q.push_back('{port: 1'b1, err: 1'b0, data: exp_p1});
    repeat (3) @(posedge clk);
    #1; spur_data = 32'hBAD0BAD0; spur_valid = 1'b1;
    @(posedge clk);
    #1; spur_valid = 1'b0;
    wait_done(40, 1);

    // p1 read; a write-complete strobe during WAIT must be ignored
    @(posedge clk); #1;
    resp_lat = 3;
    p1_addr = 24'h000200; p1_req_read = 1'b1;
    exp_p1 = rd_data(24'h000200);
    cmd_q.push_back('{write: 1'b0, addr: 24'h000200, data: '0});
    res_q.push_back('{port: 1'b1, err: 1'b0, data: exp_p1});
    repeat (3) @(posedge clk);
    #1; spur_wc = 1'b1;
    @(posedge clk);
    #1; spur_wc = 1'b0;
    wait_done(40, 1);

    // p1 read and write together: write only
    @(posedge clk); #1;
    resp_lat = 2;
    p1_addr = 24'h0003A0; p1_data_in = 32'hCAFEF00D;
    p1_req_read = 1'b1; p1_req_write = 1'b1;
    cmd_q.push_back('{write: 1'b1, addr: 24'h0003A0, data: 32'hCAFEF00D});
    res_q.push_back('{port: 1'b1, err: 1'b0, data: exp_p1});
    wait_done(40, 1);

    // stray read-valid while idle
    @(posedge clk); #1;
    spur_data = 32'h0BADF00D; spur_valid = 1'b1;
    @(posedge clk); #1;
    spur_valid = 1'b0;
    @(negedge clk);
    chk("idle_strobe_p0", p0_data_out, exp_p0);
    chk("idle_strobe_p1", p1_data_out, exp_p1);

    // watchdog timeout on p0
    @(posedge clk); #1;
    resp_en = 1'b0;
    p0_addr = 24'h000300; p0_req_read = 1'b1;
    cmd_q.push_back('{write: 1'b0, addr: 24'h000300, data: '0});
    res_q.push_back('{port: 1'b0, err: 1'b1, data: exp_p0});
    wait_done(60, 1);
    chk("timeout_latency", last_done_cyc - last_cmd_cyc, TIMEOUT + 1);
    resp_en = 1'b1;

    // both ports requesting from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    resp_lat = 3;
    exp_p0 = '0; exp_p1 = '0;
    p0_addr = 24'h000010; p0_req_read = 1'b1;
    p1_addr = 24'h000020; p1_req_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back('{write: 1'b0, addr: (i % 2 == 0) ? 24'h000010 : 24'h000020, data: '0});
      res_q.push_back('{port: (i % 2 == 1), err: 1'b0,
                        data: rd_data((i % 2 == 0) ? 24'h000010 : 24'h000020)});
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(40, i == 3);
    exp_p0 = rd_data(24'h000010);
    exp_p1 = rd_data(24'h000020);

    // reset during WAIT, DRAM answers after release
    @(posedge clk); #1;
    resp_lat = 4;
    p1_addr = 24'h000400; p1_req_read = 1'b1;
    cmd_q.push_back('{write: 1'b0, addr: 24'h000400, data: '0});
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0; p1_req_read = 1'b0;
    @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_ctrl", {busy, grant, dram_req_read, dram_req_write, p0_done, p1_done, p0_err, p1_err}, 0);
      chk("abort_data", {p0_data_out, p1_data_out}, 0);
    end
    chk("abort_dram", {dram_addr, dram_data_in}, 0);

    chk("sb_cmd_empty", cmd_q.size(), 0);
    chk("sb_res_empty", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
